// File: rtl/cosim_commit_scoreboard.sv
// cosim_commit_scoreboard: buffers DUT register-write commits and reference-model entries
// in two FIFOs, compares them pairwise in order and reports matches and mismatches.
module cosim_commit_scoreboard #(
  parameter int NumPorts = 2,
  parameter int Depth = 16,
  parameter int KeyW = 64,
  parameter int ValW = 128,
  parameter bit IgnoreCsrValue = 1'b1,
  parameter bit StopOnMismatch = 1'b1,
  parameter int CntW = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumPorts-1:0]      dut_valid_i,
  input  logic [NumPorts*KeyW-1:0] dut_key_i,
  input  logic [NumPorts*ValW-1:0] dut_value_i,
  output logic                     dut_ready_o,
  input  logic                     exp_valid_i,
  input  logic [KeyW-1:0]          exp_key_i,
  input  logic [ValW-1:0]          exp_value_i,
  output logic                     exp_ready_o,
  input  logic                     flush_i,
  output logic                     mismatch_o,
  output logic [KeyW-1:0]          mis_key_o,
  output logic [ValW-1:0]          mis_exp_value_o,
  output logic [ValW-1:0]          mis_dut_value_o,
  output logic [CntW-1:0]          match_cnt_o,
  output logic [CntW-1:0]          mismatch_cnt_o,
  output logic                     overflow_o,
  output logic                     halted_o
);
  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;
  localparam logic [AW:0] Full = Depth[AW:0];
  localparam logic [AW:0] DutLim = Depth[AW:0] - NumPorts[AW:0];
  typedef enum logic {RUN, HALTED} state_e;
  state_e state_q, state_d;
  logic [KeyW-1:0] dkey_mem [Depth];
  logic [ValW-1:0] dval_mem [Depth];
  logic [KeyW-1:0] ekey_mem [Depth];
  logic [ValW-1:0] eval_mem [Depth];
  logic [AW-1:0] dwp, drp, ewp, erp;
  logic [AW:0] dcnt, ecnt, n_push;
  logic [AW-1:0] waddr [NumPorts];
  logic dut_push, exp_push, pop, eq;
  logic [KeyW-1:0] hkey;
  logic [ValW-1:0] hev, hdv;
  assign dut_ready_o = dcnt <= DutLim;
  assign exp_ready_o = ecnt != Full;
  assign dut_push = (|dut_valid_i) & dut_ready_o & ~flush_i;
  assign exp_push = exp_valid_i & exp_ready_o & ~flush_i;
  assign pop = (state_q == RUN) & (dcnt != '0) & (ecnt != '0) & ~flush_i;
  assign hkey = ekey_mem[erp];
  assign hev = eval_mem[erp];
  assign hdv = dval_mem[drp];
  assign eq = (hkey == dkey_mem[drp]) & ((hev == hdv) | (IgnoreCsrValue & (hkey[3:0] == 4'b0100)));
  assign halted_o = state_q == HALTED;
  // Valid ports are packed into consecutive slots in ascending port order.
  always_comb begin
    n_push = '0;
    for (int p = 0; p < NumPorts; p++) begin
      waddr[p] = dwp + n_push[AW-1:0];
      n_push = n_push + CW'(dut_valid_i[p]);
    end
  end
  always_comb begin
    state_d = flush_i ? RUN : (StopOnMismatch && pop && !eq) ? HALTED : state_q;
  end
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NumPorts; p++) begin
      if (dut_push && dut_valid_i[p]) begin
        dkey_mem[waddr[p]] <= dut_key_i[p*KeyW +: KeyW];
        dval_mem[waddr[p]] <= dut_value_i[p*ValW +: ValW];
      end
    end
    if (exp_push) begin
      ekey_mem[ewp] <= exp_key_i;
      eval_mem[ewp] <= exp_value_i;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      dwp <= '0;
      drp <= '0;
      ewp <= '0;
      erp <= '0;
      dcnt <= '0;
      ecnt <= '0;
      mismatch_o <= 1'b0;
      mis_key_o <= '0;
      mis_exp_value_o <= '0;
      mis_dut_value_o <= '0;
      match_cnt_o <= '0;
      mismatch_cnt_o <= '0;
      overflow_o <= 1'b0;
    end else begin
      state_q <= state_d;
      dwp <= flush_i ? '0 : dwp + (dut_push ? n_push[AW-1:0] : '0);
      drp <= flush_i ? '0 : drp + AW'(pop);
      ewp <= flush_i ? '0 : ewp + AW'(exp_push);
      erp <= flush_i ? '0 : erp + AW'(pop);
      dcnt <= flush_i ? '0 : dcnt + (dut_push ? n_push : '0) - CW'(pop);
      ecnt <= flush_i ? '0 : ecnt + CW'(exp_push) - CW'(pop);
      mismatch_o <= pop & ~eq;
      if (pop && !eq) begin
        mis_key_o <= hkey;
        mis_exp_value_o <= hev;
        mis_dut_value_o <= hdv;
      end
      if (pop && eq && !(&match_cnt_o)) match_cnt_o <= match_cnt_o + 1'b1;
      if (pop && !eq && !(&mismatch_cnt_o)) mismatch_cnt_o <= mismatch_cnt_o + 1'b1;
      if ((|dut_valid_i) && !dut_ready_o) overflow_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cosim_commit_scoreboard.sv
// tb_cosim_commit_scoreboard: vector table plus scoreboard queue of expected compare
// results, with directed sequences for ordering, flush, overflow, saturation and reset.
module tb_cosim_commit_scoreboard;
  localparam int NP = 2, DEP = 16, KW = 64, VW = 128, CW = 8;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [NP-1:0] dut_valid;
  logic [NP*KW-1:0] dut_key;
  logic [NP*VW-1:0] dut_value;
  logic dut_ready, exp_valid, exp_ready, flush, mismatch, overflow, halted;
  logic [KW-1:0] exp_key, mis_key;
  logic [VW-1:0] exp_value, mis_exp_value, mis_dut_value;
  logic [CW-1:0] match_cnt, mismatch_cnt;

  cosim_commit_scoreboard #(.NumPorts(NP), .Depth(DEP), .KeyW(KW), .ValW(VW),
    .IgnoreCsrValue(1'b1), .StopOnMismatch(1'b1), .CntW(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .dut_valid_i(dut_valid), .dut_key_i(dut_key),
    .dut_value_i(dut_value), .dut_ready_o(dut_ready), .exp_valid_i(exp_valid),
    .exp_key_i(exp_key), .exp_value_i(exp_value), .exp_ready_o(exp_ready),
    .flush_i(flush), .mismatch_o(mismatch), .mis_key_o(mis_key),
    .mis_exp_value_o(mis_exp_value), .mis_dut_value_o(mis_dut_value),
    .match_cnt_o(match_cnt), .mismatch_cnt_o(mismatch_cnt), .overflow_o(overflow),
    .halted_o(halted));

  always #5 clk = ~clk;

  typedef struct {
    logic [KW-1:0] ek;
    logic [VW-1:0] ev;
    logic [KW-1:0] dk;
    logic [VW-1:0] dv;
    logic mis;
  } vec_t;
  typedef struct {
    logic mis;
    logic [KW-1:0] k;
    logic [VW-1:0] ev;
    logic [VW-1:0] dv;
  } res_t;

  vec_t tbl[8];
  res_t sb[$];
  int errors = 0, checks = 0;
  int em = 0, ex = 0;
  logic [CW-1:0] last_mc = '0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic monitor();
    res_t e;
    if (mon_en && (mismatch || match_cnt != last_mc)) begin
      if (sb.size() == 0) chk("unexpected_result", VW'(1), VW'(0));
      else begin
        e = sb.pop_front();
        chk("sb_mismatch", VW'(mismatch), VW'(e.mis));
        if (e.mis) begin
          chk("sb_mis_key", VW'(mis_key), VW'(e.k));
          chk("sb_mis_exp_value", mis_exp_value, e.ev);
          chk("sb_mis_dut_value", mis_dut_value, e.dv);
        end
      end
    end
    last_mc = match_cnt;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    monitor();
  endtask

  task automatic idle();
    dut_valid = '0;
    exp_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic drive_pair(input logic [KW-1:0] ek, input logic [VW-1:0] ev,
                            input logic [KW-1:0] dk, input logic [VW-1:0] dv, input logic mis);
    exp_valid = 1'b1;
    exp_key = ek;
    exp_value = ev;
    dut_valid = 2'b01;
    dut_key = {KW'(0), dk};
    dut_value = {VW'(0), dv};
    sb.push_back('{mis, ek, ev, dv});
    if (mis) ex++; else em++;
  endtask

  function automatic logic [CW-1:0] sat(input int v);
    return (v > 255) ? CW'(255) : CW'(v);
  endfunction

  initial begin
    tbl[0] = '{64'h21, 128'd5, 64'h21, 128'd5, 1'b0};
    tbl[1] = '{64'h3000_0304, 128'd1, 64'h3000_0304, 128'd2, 1'b0};
    tbl[2] = '{64'h44, 128'd9, 64'h44, 128'd9, 1'b0};
    tbl[3] = '{64'h51, 128'd7, 64'h51, 128'd8, 1'b1};
    tbl[4] = '{64'h35, 128'd1, 64'h35, 128'd2, 1'b1};
    tbl[5] = '{64'h77, 128'd3, 64'h78, 128'd3, 1'b1};
    tbl[6] = '{64'h104, 128'd3, 64'h105, 128'd3, 1'b1};
    tbl[7] = '{64'hDEAD_BEEF_0000_0001, {4{32'hCAFE_F00D}}, 64'hDEAD_BEEF_0000_0001, {4{32'hCAFE_F00D}}, 1'b0};
    idle();
    dut_key = '0;
    dut_value = '0;
    exp_key = '0;
    exp_value = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_dut_ready", VW'(dut_ready), VW'(1));
    chk("rst_exp_ready", VW'(exp_ready), VW'(1));
    chk("rst_halted", VW'(halted), VW'(0));
    chk("rst_mismatch", VW'(mismatch), VW'(0));
    chk("rst_overflow", VW'(overflow), VW'(0));
    chk("rst_match_cnt", VW'(match_cnt), VW'(0));
    chk("rst_mismatch_cnt", VW'(mismatch_cnt), VW'(0));
    chk("rst_mis_key", VW'(mis_key), VW'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_mc = '0;
    mon_en = 1'b1;

    foreach (tbl[i]) begin
      drive_pair(tbl[i].ek, tbl[i].ev, tbl[i].dk, tbl[i].dv, tbl[i].mis);
      step();
      idle();
      step();
      step();
      chk("tbl_halted", VW'(halted), VW'(tbl[i].mis));
      chk("tbl_pulse_width", VW'(mismatch), VW'(0));
      chk("tbl_match_cnt", VW'(match_cnt), VW'(sat(em)));
      chk("tbl_mismatch_cnt", VW'(mismatch_cnt), VW'(sat(ex)));
      if (tbl[i].mis) begin
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("tbl_flush_unhalt", VW'(halted), VW'(0));
      end
    end

    // Two ports in one cycle must compare in port order; then a lone port 1.
    dut_valid = 2'b11;
    dut_key = {64'hB1, 64'hA1};
    dut_value = {VW'(2), VW'(1)};
    exp_valid = 1'b1;
    exp_key = 64'hA1;
    exp_value = 128'd1;
    sb.push_back('{1'b0, 64'hA1, 128'd1, 128'd1});
    sb.push_back('{1'b0, 64'hB1, 128'd2, 128'd2});
    em += 2;
    step();
    dut_valid = 2'b00;
    exp_key = 64'hB1;
    exp_value = 128'd2;
    step();
    idle();
    step();
    step();
    chk("order_match_cnt", VW'(match_cnt), VW'(sat(em)));
    chk("order_halted", VW'(halted), VW'(0));
    dut_valid = 2'b10;
    dut_key = {64'hC1, 64'h0};
    dut_value = {VW'(3), VW'(0)};
    exp_valid = 1'b1;
    exp_key = 64'hC1;
    exp_value = 128'd3;
    sb.push_back('{1'b0, 64'hC1, 128'd3, 128'd3});
    em++;
    step();
    idle();
    step();
    step();
    chk("gap_match_cnt", VW'(match_cnt), VW'(sat(em)));

    // Halt, queue entries, fill the expected FIFO, then flush with concurrent pushes.
    drive_pair(64'h90, 128'd1, 64'h90, 128'd2, 1'b1);
    step();
    idle();
    step();
    step();
    chk("halt_state", VW'(halted), VW'(1));
    for (int i = 0; i < DEP + 1; i++) begin
      exp_valid = 1'b1;
      exp_key = KW'(32'h100 + i);
      exp_value = VW'(i);
      dut_valid = (i < 4) ? 2'b11 : 2'b00;
      dut_key = {KW'(32'h500 + 2 * i + 1), KW'(32'h500 + 2 * i)};
      step();
    end
    idle();
    step();
    chk("halt_no_pop_match", VW'(match_cnt), VW'(sat(em)));
    chk("halt_no_pop_mismatch", VW'(mismatch_cnt), VW'(sat(ex)));
    chk("exp_full_ready", VW'(exp_ready), VW'(0));
    chk("exp_backpressure_no_ovf", VW'(overflow), VW'(0));
    chk("halt_dut_ready", VW'(dut_ready), VW'(1));
    flush = 1'b1;
    exp_valid = 1'b1;
    dut_valid = 2'b11;
    step();
    idle();
    chk("flush_halted", VW'(halted), VW'(0));
    chk("flush_exp_ready", VW'(exp_ready), VW'(1));
    chk("flush_match_cnt", VW'(match_cnt), VW'(sat(em)));
    chk("flush_mismatch_cnt", VW'(mismatch_cnt), VW'(sat(ex)));
    chk("flush_mis_key", VW'(mis_key), VW'(64'h90));
    step();
    step();
    drive_pair(64'hAB, 128'd1, 64'hAB, 128'd1, 1'b0);
    step();
    idle();
    step();
    step();
    chk("post_flush_match_cnt", VW'(match_cnt), VW'(sat(em)));

    // Fill the DUT FIFO to Depth-1, then an extra commit must be dropped.
    for (int i = 0; i < 8; i++) begin
      dut_valid = (i < 7) ? 2'b11 : 2'b01;
      dut_key = {KW'(32'h200 + 2 * i + 1), KW'(32'h200 + 2 * i)};
      dut_value = {VW'(32'h200 + 2 * i + 1), VW'(32'h200 + 2 * i)};
      if (i == 7) chk("ready_at_14", VW'(dut_ready), VW'(1));
      step();
    end
    idle();
    chk("ready_at_15", VW'(dut_ready), VW'(0));
    chk("no_ovf_yet", VW'(overflow), VW'(0));
    dut_valid = 2'b01;
    dut_key = {KW'(0), 64'hBAD};
    step();
    idle();
    chk("overflow_set", VW'(overflow), VW'(1));
    chk("overflow_ready", VW'(dut_ready), VW'(0));
    for (int i = 0; i < 16; i++) begin
      exp_valid = 1'b1;
      exp_key = (i < 15) ? KW'(32'h200 + i) : 64'h999;
      exp_value = (i < 15) ? VW'(32'h200 + i) : VW'(0);
      if (i < 15) begin
        sb.push_back('{1'b0, exp_key, exp_value, exp_value});
        em++;
      end
      step();
    end
    idle();
    step();
    step();
    chk("drain_match_cnt", VW'(match_cnt), VW'(sat(em)));
    chk("drain_dut_ready", VW'(dut_ready), VW'(1));
    flush = 1'b1;
    step();
    idle();
    chk("overflow_sticky", VW'(overflow), VW'(1));

    // Counter saturation.
    mon_en = 1'b0;
    for (int i = 0; i < 240; i++) begin
      exp_valid = 1'b1;
      exp_key = 64'h300;
      exp_value = VW'(i);
      dut_valid = 2'b01;
      dut_key = {KW'(0), 64'h300};
      dut_value = {VW'(0), VW'(i)};
      em++;
      step();
    end
    idle();
    step();
    step();
    chk("sat_match_cnt", VW'(match_cnt), VW'(sat(em)));
    chk("sat_mismatch_cnt", VW'(mismatch_cnt), VW'(sat(ex)));

    // Reset while a mismatching pair is about to be compared.
    drive_pair(64'h400, 128'd1, 64'h400, 128'd2, 1'b1);
    void'(sb.pop_back());
    step();
    idle();
    rst_n = 1'b0;
    #1;
    chk("midrst_match_cnt", VW'(match_cnt), VW'(0));
    chk("midrst_mismatch", VW'(mismatch), VW'(0));
    #1 rst_n = 1'b1;
    last_mc = '0;
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_no_pulse", VW'(mismatch), VW'(0));
    end
    chk("midrst_mismatch_cnt", VW'(mismatch_cnt), VW'(0));
    chk("midrst_halted", VW'(halted), VW'(0));
    chk("sb_empty", VW'(sb.size()), VW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
